// File: rtl/range_peak.sv
// ---------------------------------------------------------------------------
// range_peak
//
// Sequencer/reducer sitting directly downstream of the `range` block. On a
// request it launches one `range` run at the requested base value and waits
// for that run to finish. It then reads back every stored iteration count
// through `range`'s read port. Finally it reports the largest count, the
// address of that count, and the Collatz start value that produced it.
//
// Optional feature macro: RANGE_PEAK_TOTAL_EN
//   defined   -> `total` accumulates the sum of every count read back
//   undefined -> no accumulator is built and `total` is tied to zero
//
// Handshakes (valid/ready semantics):
//   - `req` is a request strobe. It is accepted only while the block is idle,
//     that is, while `busy` is low. `base` is captured in the same cycle.
//   - `valid` is a one-cycle strobe with no back-pressure. The peak outputs
//     and `total` are valid from that cycle on. They stay stable until the
//     next accepted `req`.
//   - `rgo` is a one-cycle strobe towards `range`. `rdone` is a one-cycle
//     strobe coming back from `range`, and it is honoured only while waiting.
//
// Ports:
//   clk         in  1      rising-edge clock
//   reset       in  1      asynchronous active-high reset
//   req         in  1      start a run (sampled only when idle)
//   base        in  32     first Collatz start value
//   rgo         out 1      drives range.go
//   rstart      out 32     drives range.start (base during launch/wait,
//                          read address while scanning)
//   rdone       in  1      range.done pulse
//   rcount      in  16     range.count, registered read data
//   busy        out 1      high whenever not idle
//   valid       out 1      one-cycle result strobe
//   peak_count  out 16     largest count read
//   peak_index  out AB     address of peak_count
//   peak_n      out 32     base + peak_index (wraps modulo 2^32)
//   total       out 16+AB  sum of counts (zero when the feature is off)
//   dbg_state   out 3      current FSM state, for observation only
// ---------------------------------------------------------------------------
module range_peak #(
    parameter int RAM_WORDS     = 16,
    parameter int RAM_ADDR_BITS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req,
    input  logic [31:0]                 base,
    output logic                        rgo,
    output logic [31:0]                 rstart,
    input  logic                        rdone,
    input  logic [15:0]                 rcount,
    output logic                        busy,
    output logic                        valid,
    output logic [15:0]                 peak_count,
    output logic [RAM_ADDR_BITS-1:0]    peak_index,
    output logic [31:0]                 peak_n,
    output logic [16+RAM_ADDR_BITS-1:0] total,
    output logic [2:0]                  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_SCAN   = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(RAM_WORDS - 1);

    state_t                     state_q, state_d;
    logic [31:0]                base_q, base_d;
    logic [RAM_ADDR_BITS-1:0]   a_q, a_d;
    logic                       issued_q, issued_d;     // last address already presented
    logic                       cap_q, cap_d;           // rcount belongs to cap_addr_q
    logic [RAM_ADDR_BITS-1:0]   cap_addr_q, cap_addr_d;
    logic                       rgo_q, rgo_d;
    logic [15:0]                peak_count_q, peak_count_d;
    logic [RAM_ADDR_BITS-1:0]   peak_index_q, peak_index_d;
    logic [31:0]                peak_n_q, peak_n_d;

    // Clear/capture strobes shared with the optional accumulator.
    logic                       clear_acc;
    logic                       capture;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            a_q          <= '0;
            issued_q     <= 1'b0;
            cap_q        <= 1'b0;
            cap_addr_q   <= '0;
            rgo_q        <= 1'b0;
            peak_count_q <= '0;
            peak_index_q <= '0;
            peak_n_q     <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            a_q          <= a_d;
            issued_q     <= issued_d;
            cap_q        <= cap_d;
            cap_addr_q   <= cap_addr_d;
            rgo_q        <= rgo_d;
            peak_count_q <= peak_count_d;
            peak_index_q <= peak_index_d;
            peak_n_q     <= peak_n_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        a_d          = a_q;
        issued_d     = issued_q;
        cap_d        = 1'b0;
        cap_addr_d   = cap_addr_q;
        rgo_d        = 1'b0;
        peak_count_d = peak_count_q;
        peak_index_d = peak_index_q;
        peak_n_d     = peak_n_q;
        clear_acc    = 1'b0;
        capture      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    base_d       = base;
                    peak_count_d = '0;
                    peak_index_d = '0;
                    // peak_n tracks base + peak_index, so with index 0 it
                    // starts at base. That also covers the all-zero case.
                    peak_n_d     = base;
                    clear_acc    = 1'b1;
                    state_d      = S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                // rgo is registered. The pulse therefore lands in the first
                // WAIT cycle and lasts exactly one cycle.
                rgo_d   = 1'b1;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (rdone) begin
                    a_d      = '0;
                    issued_d = 1'b0;
                    state_d  = S_SCAN;
                end
            end

            S_SCAN: begin
                // Present address a_q. The registered read data shows up one
                // cycle later, so a delayed flag and a delayed address follow it.
                cap_d      = !issued_q;
                cap_addr_d = a_q;
                if (a_q == LAST_ADDR) begin
                    issued_d = 1'b1;
                end else begin
                    a_d = a_q + 1'b1;
                end

                if (cap_q) begin
                    capture = 1'b1;
                    // Strict compare: on a tie the earliest address is kept.
                    if (rcount > peak_count_q) begin
                        peak_count_d = rcount;
                        peak_index_d = cap_addr_q;
                        peak_n_d     = base_q + 32'(cap_addr_q);
                    end
                    if (cap_addr_q == LAST_ADDR) begin
                        state_d = S_REPORT;
                    end
                end
            end

            S_REPORT: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef RANGE_PEAK_TOTAL_EN
    // -----------------------------------------------------------------------
    // Optional running sum of all captured counts. It cannot overflow:
    // at most RAM_WORDS * 65535 fits in 16 + RAM_ADDR_BITS bits.
    // -----------------------------------------------------------------------
    logic [16+RAM_ADDR_BITS-1:0] total_q, total_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    always_comb begin
        total_d = total_q;
        if (clear_acc) begin
            total_d = '0;
        end else if (capture) begin
            total_d = total_q + (16 + RAM_ADDR_BITS)'(rcount);
        end
    end

    assign total = total_q;
`else
    assign total = '0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The status outputs decode the state register directly. Reset therefore
    // clears them immediately, without waiting for a clock edge.
    assign busy       = (state_q != S_IDLE);
    assign valid      = (state_q == S_REPORT);
    assign rgo        = rgo_q;
    assign rstart     = (state_q == S_SCAN) ? 32'(a_q) : base_q;
    assign peak_count = peak_count_q;
    assign peak_index = peak_index_q;
    assign peak_n     = peak_n_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_range_peak.sv
// ---------------------------------------------------------------------------
// tb_range_peak
//
// Directed bench for range_peak. A behavioural stand-in for `range` answers
// each accepted go with a done pulse a few cycles later. It also serves
// registered read data from a small memory that the bench preloads before
// every run. Expected results are computed by hand for each memory pattern.
// ---------------------------------------------------------------------------
module tb_range_peak;

  localparam int RAM_WORDS = 16;
  localparam int AB        = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              req;
  logic [31:0]       base;
  logic              rgo;
  logic [31:0]       rstart;
  logic              rdone;
  logic [15:0]       rcount;
  logic              busy;
  logic              valid;
  logic [15:0]       peak_count;
  logic [AB-1:0]     peak_index;
  logic [31:0]       peak_n;
  logic [16+AB-1:0]  total;
  logic [2:0]        dbg_state;

  range_peak #(.RAM_WORDS(RAM_WORDS), .RAM_ADDR_BITS(AB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .base       (base),
    .rgo        (rgo),
    .rstart     (rstart),
    .rdone      (rdone),
    .rcount     (rcount),
    .busy       (busy),
    .valid      (valid),
    .peak_count (peak_count),
    .peak_index (peak_index),
    .peak_n     (peak_n),
    .total      (total),
    .dbg_state  (dbg_state)
  );

  // ---------------- range stand-in ----------------
  logic [15:0] mem [RAM_WORDS];
  int          stub_cnt  = 0;
  logic        stub_done = 1'b0;
  logic        inj_done;

  assign rdone = stub_done | inj_done;

  always @(posedge clk) begin
    rcount    <= mem[rstart[3:0]];
    stub_done <= (stub_cnt == 1);
    if (rgo) stub_cnt <= 5;
    else if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
  end

  // ---------------- monitors ----------------
  int cyc       = 0;
  int d_cyc     = 0;
  int rgo_cnt   = 0;
  int valid_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stub_done) d_cyc <= cyc + 1;  // edge number at which rdone is sampled
  end

  always @(negedge clk) begin
    if (rgo)   rgo_cnt   <= rgo_cnt + 1;
    if (valid) valid_cnt <= valid_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill(input logic [15:0] def, input int a1, input logic [15:0] v1,
                      input int a2, input logic [15:0] v2);
    for (int i = 0; i < RAM_WORDS; i++) mem[i] = def;
    if (a1 >= 0) mem[a1] = v1;
    if (a2 >= 0) mem[a2] = v2;
  endtask

  // The caller must be away from a clock edge. This task returns #1 after
  // the edge at which rgo has just fallen.
  task automatic start_run(input string tag, input logic [31:0] b);
    req  = 1'b1;
    base = b;
    @(posedge clk); #1;                 // edge E: request accepted
    req  = 1'b0;
    base = 32'h0;
    check({tag, "_busy_after_req"}, 32'(busy), 32'd1);
    check({tag, "_rgo_not_yet"},    32'(rgo),  32'd0);
    @(posedge clk); #1;                 // edge E+1
    check({tag, "_rgo_high"},       32'(rgo),  32'd1);
    check({tag, "_rstart_base"},    rstart,    b);
    @(posedge clk); #1;                 // edge E+2
    check({tag, "_rgo_one_cycle"},  32'(rgo),  32'd0);
  endtask

  // Waits for valid with a cycle budget. It checks the latency from rdone
  // and that busy falls one cycle later. It returns during the idle cycle
  // that follows valid.
  task automatic wait_valid(input string tag);
    bit found = 1'b0;
    int lat   = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (valid) begin
        found = 1'b1;
        lat   = cyc - d_cyc;
        break;
      end
    end
    check({tag, "_valid_seen"}, 32'(found), 32'd1);
    check({tag, "_latency"},    32'(lat),   32'd17);
    check({tag, "_busy_in_valid"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({tag, "_valid_pulse"}, 32'(valid), 32'd0);
    check({tag, "_busy_fall"},   32'(busy),  32'd0);
  endtask

  task automatic check_results(input string tag, input logic [15:0] c, input logic [AB-1:0] idx,
                               input logic [31:0] n, input logic [31:0] tot);
    logic [31:0] exp_tot;
`ifdef RANGE_PEAK_TOTAL_EN
    exp_tot = tot;
`else
    exp_tot = 32'd0;
`endif
    check({tag, "_peak_count"}, 32'(peak_count), 32'(c));
    check({tag, "_peak_index"}, 32'(peak_index), 32'(idx));
    check({tag, "_peak_n"},     peak_n,          n);
    check({tag, "_total"},      32'(total),      exp_tot);
  endtask

  task automatic wait_scan(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (dbg_state == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_scan_reached"}, 32'(found), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int rgo0;
  int val0;

  initial begin
    reset    = 1'b1;
    req      = 1'b0;
    base     = 32'h0;
    inj_done = 1'b0;
    fill(16'd0, -1, 16'd0, -1, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_valid",      32'(valid),      32'd0);
    check("rst_rgo",        32'(rgo),        32'd0);
    check("rst_rstart",     rstart,          32'd0);
    check("rst_peak_count", 32'(peak_count), 32'd0);
    check("rst_peak_index", 32'(peak_index), 32'd0);
    check("rst_peak_n",     peak_n,          32'd0);
    check("rst_total",      32'(total),      32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic run: {3,7,2,...,2} at base 100.
    fill(16'd2, 0, 16'd3, 1, 16'd7);
    rgo0 = rgo_cnt;
    start_run("basic", 32'd100);
    wait_valid("basic");
    check_results("basic", 16'd7, 4'd1, 32'd101, 32'd38);
    check("basic_rgo_count", 32'(rgo_cnt - rgo0), 32'd1);

    // Tie run, requested in the cycle right after valid.
    fill(16'd9, 4, 16'd50, 12, 16'd50);
    start_run("tie", 32'd200);
    wait_valid("tie");
    check_results("tie", 16'd50, 4'd4, 32'd204, 32'd226);

    // Wrapping start value.
    @(posedge clk); #1;
    fill(16'd1, 3, 16'd20, -1, 16'd0);
    start_run("wrap", 32'hFFFF_FFFE);
    wait_valid("wrap");
    check_results("wrap", 16'd20, 4'd3, 32'd1, 32'd35);

    // All-zero counts.
    @(posedge clk); #1;
    fill(16'd0, -1, 16'd0, -1, 16'd0);
    start_run("zero", 32'd7);
    wait_valid("zero");
    check_results("zero", 16'd0, 4'd0, 32'd7, 32'd0);

    // Ignored req in WAIT and SCAN, plus an extra rdone in SCAN.
    @(posedge clk); #1;
    fill(16'd2, 0, 16'd3, 1, 16'd7);
    rgo0 = rgo_cnt;
    val0 = valid_cnt;
    start_run("ign", 32'd100);
    req  = 1'b1;
    base = 32'd555;
    @(posedge clk); #1;
    req  = 1'b0;
    wait_scan("ign");
    @(posedge clk); #1;
    @(posedge clk); #1;
    req      = 1'b1;
    inj_done = 1'b1;
    @(posedge clk); #1;
    req      = 1'b0;
    inj_done = 1'b0;
    wait_valid("ign");
    check_results("ign", 16'd7, 4'd1, 32'd101, 32'd38);
    repeat (10) @(posedge clk);
    #1;
    check("ign_rgo_count",   32'(rgo_cnt - rgo0),   32'd1);
    check("ign_valid_count", 32'(valid_cnt - val0), 32'd1);
    check("ign_stay_idle",   32'(busy),             32'd0);

    // Reset mid-SCAN, checked before any clock edge.
    start_run("rstrun", 32'd100);
    wait_scan("rstrun");
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy",       32'(busy),       32'd0);
    check("mid_rst_valid",      32'(valid),      32'd0);
    check("mid_rst_rgo",        32'(rgo),        32'd0);
    check("mid_rst_rstart",     rstart,          32'd0);
    check("mid_rst_peak_count", 32'(peak_count), 32'd0);
    check("mid_rst_peak_index", 32'(peak_index), 32'd0);
    check("mid_rst_peak_n",     peak_n,          32'd0);
    check("mid_rst_total",      32'(total),      32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    // Stale rdone while idle.
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    @(posedge clk); #1;
    check("stale_rdone_busy", 32'(busy),      32'd0);
    check("stale_rdone_state", 32'(dbg_state), 32'd0);

    // Fresh run after the reset.
    fill(16'd4, 9, 16'd11, 2, 16'd10);
    start_run("fresh", 32'd1000);
    wait_valid("fresh");
    check_results("fresh", 16'd11, 4'd9, 32'd1009, 32'd77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/range_peak.md
# range_peak

Sequencer and reducer placed directly downstream of `range`. On a request it starts one `range` run at a chosen base value and waits for the run to finish. It then reads every stored iteration count back through `range`'s read port and reports the maximum count, its address, and the Collatz start value that produced it. `range` is otherwise driven by the board buttons; this block replaces that with one request/result handshake.

## Interface

- `RAM_WORDS`, 16: number of counts `range` stores; must match `range`.
- `RAM_ADDR_BITS`, 4: `range` address width; `2**RAM_ADDR_BITS >= RAM_WORDS`.

Ports:

- `clk` in 1: single clock; everything is sampled on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 1: start a run. Sampled only in IDLE.
- `base` in 32: first Collatz start value. Captured when `req` is accepted.
- `rgo` out 1: drives `range.go`.
- `rstart` out 32: drives `range.start`.
- `rdone` in 1: from `range.done`, a one-cycle pulse.
- `rcount` in 16: from `range.count`, one-cycle registered read data.
- `busy` out 1: high in every state except IDLE.
- `valid` out 1: one-cycle pulse; results are valid from this cycle on.
- `peak_count` out 16: largest count read.
- `peak_index` out RAM_ADDR_BITS: address of `peak_count`.
- `peak_n` out 32: `base_q + peak_index`, modulo 2^32.
- `total` out 16+RAM_ADDR_BITS: sum of all counts read (see Configuration).

## Operation

- FSM states: IDLE, LAUNCH, WAIT, SCAN, REPORT.
- IDLE
  - `req`=1: capture `base` into `base_q`, clear the accumulators, go to LAUNCH.
- LAUNCH (exactly one cycle)
  - `rgo`=1, `rstart`=`base_q`, then go to WAIT.
  - `rgo` is never high for more than one cycle. A held `go` restarts `range`.
- WAIT
  - `rgo`=0, `rstart`=`base_q`.
  - `rdone`=1: go to SCAN with address counter `a`=0.
- SCAN
  - `rstart` = zero-extended `a`; `a` increments every cycle until it reaches RAM_WORDS-1, then holds.
  - A one-cycle-delayed capture flag and delayed address mark the cycles where `rcount` belongs to address `a-1`.
  - On each capture: if `rcount > peak_count`, load `peak_count` and `peak_index`. The comparison is strict, so on a tie the lowest index wins. With the macro on, add `rcount` to `total`.
  - After the capture for address RAM_WORDS-1, go to REPORT.
- REPORT (exactly one cycle)
  - `valid`=1, then go to IDLE.
  - `peak_*` and `total` hold until the next accepted `req` clears them.
- Ignored inputs
  - `req` is ignored outside IDLE.
  - `rdone` is ignored outside WAIT.
- Arithmetic and widths
  - `peak_n` is a 32-bit add that wraps.
  - `total` cannot overflow: at most 16 × 65535.
  - All-zero counts leave `peak_count`=0 and `peak_index`=0.
- Reset, at any time:
  - state goes to IDLE;
  - `rgo`, `busy`, `valid`, `peak_count`, `peak_index`, `peak_n`, `total`, `base_q` and `a` go to 0;
  - `rstart` goes to 0.
- Reset mid-run: `range` has no reset and may still emit `rdone` later. That pulse arrives while this block is in IDLE and is ignored.

## Timing

- `req` sampled high at edge E: `rgo` is high between edges E+1 and E+2, and `busy` rises after edge E.
- `rdone` sampled high at edge D: `rstart`=`i` is presented between edges D+i and D+i+1, for i = 0..RAM_WORDS-1.
- Address i is captured at edge D+i+2.
- `valid` and the final results appear after edge D+RAM_WORDS+1, which is 17 edges after D for the defaults.
- `busy` falls one cycle after `valid`.
- A `req` in the cycle after `valid` is accepted.
- Minimum `req`-to-`valid` time is 3 + RAM_WORDS + the `range` run time.

## Configuration

- `RANGE_PEAK_TOTAL_EN`
  - Defined: `total` accumulates every captured count and is valid with `valid`.
  - Undefined: the accumulator is not built and `total` is tied to 0.
- The rest of the behaviour and timing is identical in both builds.

## Test plan

- Stub `range`: `rdone` 5 cycles after `rgo`, memory {3,7,2,...,2}, `base`=100.
  - `rgo` high for exactly 1 cycle with `rstart`=100.
  - `peak_count`=7, `peak_index`=1, `peak_n`=101.
  - `valid` 17 edges after the `rdone` edge.
  - With the macro: `total`=10+14×2=38.
- Tie: memory all 9 except addresses 4 and 12 = 50.
  - `peak_index`=4, `peak_count`=50.
- Wrap: `base`=32'hFFFF_FFFE, peak at address 3.
  - `peak_n`=1.
- `req` pulsed in WAIT and SCAN, plus an extra `rdone` in SCAN.
  - Results unchanged.
  - Only one `rgo` pulse and one `valid` pulse.
- `reset` asserted mid-SCAN.
  - All outputs 0 immediately, with no clock edge needed.
  - A stale `rdone` afterwards leaves `busy`=0.
  - A fresh `req` completes correctly.
- Integration with the real `range`/`collatz`, `base`=1.
  - `peak_index`=8, `peak_n`=9 (longest trajectory in 1..16).
  - `peak_count` equals the `range` count for address 8.
